// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state, opcode and mux-select encodings for the MIPS multi-cycle control unit
package ctrl_pkg;
    typedef enum logic [4:0] {
        RESET, FETCH, FETCH_WAIT, IR_LOAD, DECODE, R_EXEC, R_WB, ADDI_EXEC, ADDI_WB,
        MEM_ADDR, LW_READ, LW_WAIT, LW_WB, SW_WRITE, BEQ, JUMP, RTE,
        EXC_EPC, EXC_READ, EXC_WAIT, EXC_JUMP
    } state_t;
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_RTE = 6'h10, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24;
    localparam logic [1:0] IORD_PC = 2'd0, IORD_ALUOUT = 2'd1, IORD_EXC = 2'd2, IORD_ALURES = 2'd3;
    localparam logic [1:0] EXC_OPCODE = 2'd0, EXC_OVF = 2'd1;
    localparam logic [2:0] WR_RT = 3'd0, WR_RD = 3'd1, WR_R29 = 3'd2, WR_R31 = 3'd4;
    localparam logic [3:0] SD_ALUOUT = 4'd0, SD_LS = 4'd1, SD_CONST = 4'd8;
    localparam logic [1:0] A_PC = 2'd0, A_REG = 2'd1, A_MDR = 2'd2;
    localparam logic [1:0] B_REG = 2'd0, B_FOUR = 2'd1, B_SEXT = 2'd2, B_SEXT_SH = 2'd3;
    localparam logic [2:0] ALU_PASSA = 3'b000, ALU_ADD = 3'b001, ALU_SUB = 3'b010, ALU_AND = 3'b011;
    localparam logic [2:0] PC_ALU = 3'd0, PC_ALUOUT = 3'd1, PC_JUMP = 3'd2, PC_EPC = 3'd4, PC_LS = 3'd5;
    localparam logic [1:0] LS_WORD = 2'd0, LS_BYTE = 2'd2;
endpackage

// File: rtl/mips_control_unit_if.sv
// mips_control_unit_if: datapath control bus; master is the control unit, slave the datapath
interface mips_control_unit_if;
    logic [5:0] opcode, funct;
    logic       overflow, eq;
    logic       pcWrite, irWrite, regWrite, memWrite, abWrite, mdrWrite, aluOutControl, epcControl;
    logic [1:0] iord, excpControl, aluSrcA, aluSrcB, lsControl;
    logic [2:0] srcWrite, aluControl, pcSource;
    logic [3:0] srcData;
    logic [4:0] state_dbg;
    modport master (
        input  opcode, funct, overflow, eq,
        output pcWrite, irWrite, regWrite, memWrite, abWrite, mdrWrite, aluOutControl, epcControl,
               iord, excpControl, aluSrcA, aluSrcB, lsControl, srcWrite, aluControl, pcSource,
               srcData, state_dbg
    );
    modport slave (
        output opcode, funct, overflow, eq,
        input  pcWrite, irWrite, regWrite, memWrite, abWrite, mdrWrite, aluOutControl, epcControl,
               iord, excpControl, aluSrcA, aluSrcB, lsControl, srcWrite, aluControl, pcSource,
               srcData, state_dbg
    );
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: maps opcode/funct to the state following DECODE and flags unsupported instructions
module ctrl_decode import ctrl_pkg::*; (
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output state_t     nextState,
    output logic       invalid
);
    logic knownFunct;
    always_comb begin
        knownFunct = funct inside {F_ADD, F_SUB, F_AND};
        nextState = opcode == OP_RTYPE ? (knownFunct ? R_EXEC : EXC_EPC) :
                    opcode == OP_ADDI ? ADDI_EXEC :
                    (opcode == OP_LW || opcode == OP_SW) ? MEM_ADDR :
                    opcode == OP_BEQ ? BEQ :
                    opcode == OP_J ? JUMP :
                    opcode == OP_RTE ? RTE : EXC_EPC;
        invalid = nextState == EXC_EPC;
    end
endmodule

// File: rtl/mips_control_unit.sv
// mips_control_unit: multi-cycle MIPS control FSM driving datapath selects and write strobes
module mips_control_unit import ctrl_pkg::*; (
    input logic clk,
    input logic reset,
    mips_control_unit_if.master bus
);
    state_t     state, nextState, decNext;
    logic       invalid, ovfTrap;
    logic [1:0] excReg;
    ctrl_decode decode (.opcode(bus.opcode), .funct(bus.funct), .nextState(decNext), .invalid(invalid));
    // logical AND never overflows, so only add/sub/addi may trap
    assign ovfTrap = bus.overflow && (state == ADDI_EXEC || bus.funct != F_AND);
    assign bus.state_dbg = state;
    always_ff @(posedge clk) begin
        if (reset) state <= RESET;
        else state <= nextState;
    end
    always_ff @(posedge clk) begin
        if (reset) excReg <= EXC_OPCODE;
        else if (state == DECODE && invalid) excReg <= EXC_OPCODE;
        else if (nextState == EXC_EPC) excReg <= EXC_OVF;
    end
    always_comb begin
        nextState = FETCH;
        case (state)
            FETCH:      nextState = FETCH_WAIT;
            FETCH_WAIT: nextState = IR_LOAD;
            IR_LOAD:    nextState = DECODE;
            DECODE:     nextState = decNext;
            R_EXEC:     nextState = ovfTrap ? EXC_EPC : R_WB;
            ADDI_EXEC:  nextState = ovfTrap ? EXC_EPC : ADDI_WB;
            MEM_ADDR:   nextState = bus.opcode == OP_LW ? LW_READ : SW_WRITE;
            LW_READ:    nextState = LW_WAIT;
            LW_WAIT:    nextState = LW_WB;
            EXC_EPC:    nextState = EXC_READ;
            EXC_READ:   nextState = EXC_WAIT;
            EXC_WAIT:   nextState = EXC_JUMP;
            default:    nextState = FETCH;
        endcase
    end
    always_comb begin
        bus.pcWrite = 1'b0;
        bus.irWrite = 1'b0;
        bus.regWrite = 1'b0;
        bus.memWrite = 1'b0;
        bus.abWrite = 1'b0;
        bus.mdrWrite = 1'b0;
        bus.aluOutControl = 1'b0;
        bus.epcControl = 1'b0;
        bus.iord = IORD_PC;
        bus.excpControl = EXC_OPCODE;
        bus.srcWrite = WR_RT;
        bus.srcData = SD_ALUOUT;
        bus.aluSrcA = A_PC;
        bus.aluSrcB = B_REG;
        bus.aluControl = ALU_PASSA;
        bus.pcSource = PC_ALU;
        bus.lsControl = LS_WORD;
        // a reset cycle suppresses every output so an aborted instruction leaves no partial write
        if (!reset) begin
            case (state)
                RESET: begin
                    bus.regWrite = 1'b1;
                    bus.srcWrite = WR_R29;
                    bus.srcData = SD_CONST;
                    bus.pcWrite = 1'b1;
                end
                FETCH: begin
                    bus.pcWrite = 1'b1;
                    bus.aluSrcB = B_FOUR;
                    bus.aluControl = ALU_ADD;
                end
                IR_LOAD: bus.irWrite = 1'b1;
                DECODE: begin
                    bus.abWrite = 1'b1;
                    bus.aluSrcB = B_SEXT_SH;
                    bus.aluControl = ALU_ADD;
                    bus.aluOutControl = 1'b1;
                end
                R_EXEC: begin
                    bus.aluSrcA = A_REG;
                    bus.aluControl = bus.funct == F_SUB ? ALU_SUB : bus.funct == F_AND ? ALU_AND : ALU_ADD;
                    bus.aluOutControl = 1'b1;
                end
                R_WB: begin
                    bus.regWrite = 1'b1;
                    bus.srcWrite = WR_RD;
                end
                ADDI_EXEC, MEM_ADDR: begin
                    bus.aluSrcA = A_REG;
                    bus.aluSrcB = B_SEXT;
                    bus.aluControl = ALU_ADD;
                    bus.aluOutControl = 1'b1;
                end
                ADDI_WB: bus.regWrite = 1'b1;
                LW_READ, SW_WRITE: begin
                    bus.iord = IORD_ALUOUT;
                    bus.memWrite = state == SW_WRITE;
                end
                LW_WAIT, EXC_WAIT: bus.mdrWrite = 1'b1;
                LW_WB: begin
                    bus.regWrite = 1'b1;
                    bus.srcData = SD_LS;
                end
                BEQ: begin
                    bus.aluSrcA = A_REG;
                    bus.aluControl = ALU_SUB;
                    bus.pcWrite = bus.eq;
                    bus.pcSource = PC_ALUOUT;
                end
                JUMP: begin
                    bus.pcWrite = 1'b1;
                    bus.pcSource = PC_JUMP;
                end
                RTE: begin
                    bus.pcWrite = 1'b1;
                    bus.pcSource = PC_EPC;
                end
                EXC_EPC: begin
                    bus.epcControl = 1'b1;
                    bus.aluSrcB = B_FOUR;
                    bus.aluControl = ALU_SUB;
                end
                EXC_READ: bus.iord = IORD_EXC;
                EXC_JUMP: begin
                    bus.pcWrite = 1'b1;
                    bus.pcSource = PC_LS;
                    bus.lsControl = LS_BYTE;
                end
                default: ;
            endcase
            bus.excpControl = state inside {EXC_EPC, EXC_READ, EXC_WAIT, EXC_JUMP} ? excReg : EXC_OPCODE;
        end
    end
endmodule

// File: tb/tb_mips_control_unit.sv
// tb_mips_control_unit: scoreboard bench; per-cycle expected output vectors are queued and compared at negedge
module tb_mips_control_unit;
    import ctrl_pkg::*;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;
    logic [35:0] expQ[$];
    string       tagQ[$];
    logic [35:0] obs;
    mips_control_unit_if bus();
    mips_control_unit dut (.clk(clk), .reset(reset), .bus(bus.master));
    always #5 clk = ~clk;
    assign obs = {bus.state_dbg, bus.pcWrite, bus.irWrite, bus.regWrite, bus.memWrite, bus.abWrite,
                  bus.mdrWrite, bus.aluOutControl, bus.epcControl, bus.iord, bus.excpControl,
                  bus.srcWrite, bus.srcData, bus.aluSrcA, bus.aluSrcB, bus.aluControl, bus.pcSource,
                  bus.lsControl};
    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // strobe byte order: pcWrite irWrite regWrite memWrite abWrite mdrWrite aluOutControl epcControl
    function automatic logic [35:0] mk(input state_t s, input logic [7:0] stb, input logic [1:0] iord,
        input logic [1:0] excp, input logic [2:0] sw, input logic [3:0] sd, input logic [1:0] a,
        input logic [1:0] b, input logic [2:0] alu, input logic [2:0] pcs, input logic [1:0] ls);
        return {5'(s), stb, iord, excp, sw, sd, a, b, alu, pcs, ls};
    endfunction
    task automatic push(input string tag, input logic [35:0] e);
        logic [4:0] st;
        st = e[35:31];
        expQ.push_back(e);
        tagQ.push_back($sformatf("%s.s%0d", tag, st));
    endtask
    task automatic pushFetch(input string tag);
        push(tag, mk(FETCH, 8'h80, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        push(tag, mk(FETCH_WAIT, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push(tag, mk(IR_LOAD, 8'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push(tag, mk(DECODE, 8'h0A, 0, 0, 0, 0, 0, 3, 1, 0, 0));
    endtask
    task automatic pushExc(input string tag, input logic [1:0] e);
        push(tag, mk(EXC_EPC, 8'h01, 0, e, 0, 0, 0, 1, 2, 0, 0));
        push(tag, mk(EXC_READ, 8'h00, 2, e, 0, 0, 0, 0, 0, 0, 0));
        push(tag, mk(EXC_WAIT, 8'h04, 0, e, 0, 0, 0, 0, 0, 0, 0));
        push(tag, mk(EXC_JUMP, 8'h80, 0, e, 0, 0, 0, 0, 0, 5, 2));
    endtask
    task automatic drain();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (expQ.size() != 0 && n < 40);
        if (expQ.size() != 0) begin
            check("timeout", 36'(expQ.size()), 36'd0);
            expQ.delete();
            tagQ.delete();
        end
        #1;
    endtask
    task automatic setIr(input logic [5:0] op, input logic [5:0] fn, input logic ovf, input logic e);
        bus.opcode = op;
        bus.funct = fn;
        bus.overflow = ovf;
        bus.eq = e;
    endtask
    always @(negedge clk) begin
        if (expQ.size() != 0) check(tagQ.pop_front(), obs, expQ.pop_front());
    end
    initial begin
        reset = 1'b1;
        setIr(6'h00, 6'h20, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        push("rst_hold", mk(RESET, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drain();
        reset = 1'b0;
        push("rst_init", mk(RESET, 8'hA0, 0, 0, 2, 8, 0, 0, 0, 0, 0));
        drain();
        setIr(OP_RTYPE, F_ADD, 1'b0, 1'b0);
        pushFetch("add");
        push("add", mk(R_EXEC, 8'h02, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        push("add", mk(R_WB, 8'h20, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        drain();
        setIr(OP_RTYPE, F_SUB, 1'b1, 1'b0);
        pushFetch("sub_ovf");
        push("sub_ovf", mk(R_EXEC, 8'h02, 0, 0, 0, 0, 1, 0, 2, 0, 0));
        pushExc("sub_ovf", 2'd1);
        drain();
        setIr(OP_RTYPE, F_AND, 1'b1, 1'b0);
        pushFetch("and_ovf");
        push("and_ovf", mk(R_EXEC, 8'h02, 0, 0, 0, 0, 1, 0, 3, 0, 0));
        push("and_ovf", mk(R_WB, 8'h20, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        drain();
        setIr(OP_ADDI, 6'h00, 1'b0, 1'b0);
        pushFetch("addi");
        push("addi", mk(ADDI_EXEC, 8'h02, 0, 0, 0, 0, 1, 2, 1, 0, 0));
        push("addi", mk(ADDI_WB, 8'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drain();
        setIr(OP_ADDI, 6'h00, 1'b1, 1'b0);
        pushFetch("addi_ovf");
        push("addi_ovf", mk(ADDI_EXEC, 8'h02, 0, 0, 0, 0, 1, 2, 1, 0, 0));
        pushExc("addi_ovf", 2'd1);
        drain();
        setIr(OP_LW, 6'h00, 1'b1, 1'b0);
        pushFetch("lw");
        push("lw", mk(MEM_ADDR, 8'h02, 0, 0, 0, 0, 1, 2, 1, 0, 0));
        push("lw", mk(LW_READ, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        push("lw", mk(LW_WAIT, 8'h04, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push("lw", mk(LW_WB, 8'h20, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        drain();
        setIr(OP_SW, 6'h00, 1'b0, 1'b0);
        pushFetch("sw");
        push("sw", mk(MEM_ADDR, 8'h02, 0, 0, 0, 0, 1, 2, 1, 0, 0));
        push("sw", mk(SW_WRITE, 8'h10, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        drain();
        for (int e = 0; e < 2; e++) begin
            setIr(OP_BEQ, 6'h00, 1'b0, e[0]);
            pushFetch("beq");
            push("beq", mk(BEQ, e[0] ? 8'h80 : 8'h00, 0, 0, 0, 0, 1, 0, 2, 1, 0));
            drain();
        end
        setIr(OP_J, 6'h00, 1'b0, 1'b0);
        pushFetch("j");
        push("j", mk(JUMP, 8'h80, 0, 0, 0, 0, 0, 0, 0, 2, 0));
        drain();
        setIr(OP_RTE, 6'h00, 1'b0, 1'b0);
        pushFetch("rte");
        push("rte", mk(RTE, 8'h80, 0, 0, 0, 0, 0, 0, 0, 4, 0));
        drain();
        setIr(6'h3F, 6'h00, 1'b0, 1'b0);
        pushFetch("badop");
        pushExc("badop", 2'd0);
        drain();
        setIr(OP_RTYPE, 6'h21, 1'b1, 1'b0);
        pushFetch("badfn");
        pushExc("badfn", 2'd0);
        drain();
        setIr(OP_LW, 6'h00, 1'b0, 1'b0);
        pushFetch("lw_rst");
        push("lw_rst", mk(MEM_ADDR, 8'h02, 0, 0, 0, 0, 1, 2, 1, 0, 0));
        push("lw_rst", mk(LW_READ, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        drain();
        reset = 1'b1;
        push("lw_rst", mk(LW_WAIT, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drain();
        reset = 1'b0;
        push("lw_rst", mk(RESET, 8'hA0, 0, 0, 2, 8, 0, 0, 0, 0, 0));
        drain();
        setIr(OP_RTYPE, F_ADD, 1'b0, 1'b0);
        pushFetch("add2");
        push("add2", mk(R_EXEC, 8'h02, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        push("add2", mk(R_WB, 8'h20, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        push("add2", mk(FETCH, 8'h80, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
